ov7670_config_seq: RTL and testbench

Register-initialisation sequencer for the OV7670 camera. After a `start` pulse it walks a fixed table of {register, value} pairs and writes them one at a time to a downstream SCCB write engine through a valid/ready request plus a done/nack completion. It also executes embedded millisecond delays and retries NACKed writes. It is the configuring controller for the pixel-capture path: it sets RGB565 output and the 320x240 or 160x120 scaling that the capture block expects.

---
 rtl/ov7670_config_seq.sv | 167 ++++++++++++++++
 tb/tb_ov7670_config_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_seq.sv
// OV7670 register-initialisation sequencer: walks a fixed
// {reg,val} table, issuing SCCB writes, ms delays and NACK retries.
// Ports: clk/rst (async, active-high); start/mode begin a pass;
// sccb_valid/ready/id/reg/data request a write and sccb_done/nack
// complete it; busy/done/error/index report pass status.
module ov7670_config_seq #(
  parameter int         CYCLES_PER_MS = 25000,
  parameter logic [7:0] CAM_ID        = 8'h42,
  parameter int         MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  output logic       sccb_valid,
  output logic [7:0] sccb_id,
  output logic [7:0] sccb_reg,
  output logic [7:0] sccb_data,
  input  logic       sccb_ready,
  input  logic       sccb_done,
  input  logic       sccb_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DELAY,
    S_FINISH,
    S_FAIL
  } state_t;

  localparam logic [31:0] CPM  = 32'(CYCLES_PER_MS);
  localparam logic [7:0]  RMAX = 8'(MAX_RETRY);

  function automatic logic [15:0] rom(
    input logic [3:0] i,
    input logic       m
  );
    case (i)
      4'd0:    rom = 16'h1280;
      4'd1:    rom = 16'hF00A;
      4'd2:    rom = 16'h1204;
      4'd3:    rom = 16'h40D0;
      4'd4:    rom = 16'h8C00;
      4'd5:    rom = 16'h3A04;
      4'd6:    rom = 16'h1100;
      4'd7:    rom = 16'h0C04;
      4'd8:    rom = m ? 16'h3E1A : 16'h3E19;
      4'd9:    rom = 16'h703A;
      4'd10:   rom = 16'h7135;
      4'd11:   rom = m ? 16'h7222 : 16'h7211;
      4'd12:   rom = m ? 16'h73F2 : 16'h73F1;
      4'd13:   rom = 16'hA202;
      default: rom = 16'hFFFF;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [7:0]  retry_q, retry_d;
  logic        mode_q, mode_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      retry_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      retry_q <= retry_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    retry_d = retry_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    data_d  = data_q;
    entry   = rom(index_q, mode_q);
    case (state_q)
      S_IDLE, S_FINISH, S_FAIL: begin
        if (start) begin
          index_d = '0;
          retry_d = '0;
          mode_d  = mode;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (entry == 16'hFFFF) begin
          state_d = S_FINISH;
        end else if (entry[15:8] == 8'hF0) begin
          cnt_d   = 32'(entry[7:0]) * CPM;
          state_d = S_DELAY;
        end else begin
          reg_d   = entry[15:8];
          data_d  = entry[7:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sccb_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sccb_done) begin
          if (!sccb_nack) begin
            index_d = index_q + 4'd1;
            retry_d = '0;
            state_d = S_FETCH;
          end else if (retry_q < RMAX) begin
            // refetch the same entry so a retry
            // re-issues with normal write timing
            retry_d = retry_q + 8'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_DELAY: begin
        // exit on 1 so FETCH-to-FETCH is v*CPM+1
        if (cnt_q <= 32'd1) begin
          index_d = index_q + 4'd1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sccb_valid = (state_q == S_ISSUE);
  assign sccb_id    = CAM_ID;
  assign sccb_reg   = reg_q;
  assign sccb_data  = data_q;
  assign busy       = (state_q == S_FETCH) ||
                      (state_q == S_ISSUE) ||
                      (state_q == S_WAIT)  ||
                      (state_q == S_DELAY);
  assign done       = (state_q == S_FINISH);
  assign error      = (state_q == S_FAIL);
  assign index      = index_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Testbench for ov7670_config_seq: SCCB engine model with random
// latency/ready and NACK injection, checked against a table model.
module tb_ov7670_config_seq;

  localparam int CPM = 20;
  localparam int MR  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       sccb_ready = 1'b0;
  logic       sccb_done = 1'b0;
  logic       sccb_nack = 1'b0;
  logic       sccb_valid;
  logic [7:0] sccb_id, sccb_reg, sccb_data;
  logic       busy, done, error;
  logic [3:0] index;

  ov7670_config_seq #(
    .CYCLES_PER_MS(CPM),
    .CAM_ID(8'h42),
    .MAX_RETRY(MR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .sccb_valid(sccb_valid),
    .sccb_id(sccb_id),
    .sccb_reg(sccb_reg),
    .sccb_data(sccb_data),
    .sccb_ready(sccb_ready),
    .sccb_done(sccb_done),
    .sccb_nack(sccb_nack),
    .busy(busy),
    .done(done),
    .error(error),
    .index(index)
  );

  always #5 clk = ~clk;

  // engine configuration, written only by the main sequence
  bit rnd_rdy   = 1'b0;
  int lat_lo    = 3;
  int lat_hi    = 3;
  int nack_plan = 0;
  bit stall_en  = 1'b0;
  int inj_req   = 0;

  // engine state, written only by the engine
  int          cyc = 0;
  int          dcnt = 0;
  int          nack_left = 0;
  int          stall_left = 0;
  int          stall_ok = 0;
  int          inj_ack = 0;
  logic [7:0]  last_reg = 8'h00;
  logic [15:0] wlog[$];
  int          wcyc[$];

  always @(negedge clk) begin
    cyc++;
    sccb_done = 1'b0;
    sccb_nack = 1'b0;
    if (rst) begin
      wlog.delete();
      wcyc.delete();
      nack_left  = nack_plan;
      stall_left = stall_en ? 20 : 0;
      stall_ok   = 0;
      sccb_ready = 1'b0;
    end else begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          sccb_done = 1'b1;
          if (last_reg == 8'h3A && nack_left > 0) begin
            sccb_nack = 1'b1;
            nack_left--;
          end
        end
      end
      if (inj_req != inj_ack) begin
        sccb_done = 1'b1;
        inj_ack   = inj_req;
      end
      if (stall_left > 0 && sccb_valid && sccb_reg == 8'h40) begin
        sccb_ready = 1'b0;
        stall_left--;
        if (sccb_data == 8'hD0) stall_ok++;
      end else begin
        sccb_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (sccb_valid && sccb_ready) begin
        wlog.push_back({sccb_reg, sccb_data});
        wcyc.push_back(cyc);
        dcnt     = $urandom_range(lat_lo, lat_hi);
        last_reg = sccb_reg;
      end
    end
  end

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  bit          exp_err;
  int          exp_idx;

  // expected write list straight from the table rules
  function automatic void model(input bit m, input int nacks);
    logic [15:0] t[$];
    t = '{16'h1280, 16'hF00A, 16'h1204, 16'h40D0, 16'h8C00,
          16'h3A04, 16'h1100, 16'h0C04,
          m ? 16'h3E1A : 16'h3E19, 16'h703A, 16'h7135,
          m ? 16'h7222 : 16'h7211, m ? 16'h73F2 : 16'h73F1,
          16'hA202, 16'hFFFF};
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = 0;
    foreach (t[i]) begin
      if (t[i] == 16'hFFFF) break;
      if (t[i][15:8] == 8'hF0) continue;
      if (t[i][15:8] == 8'h3A) begin
        int tries;
        tries = (nacks > MR) ? MR + 1 : nacks + 1;
        repeat (tries) exp_q.push_back(t[i]);
        if (nacks > MR) begin
          exp_err = 1'b1;
          exp_idx = i;
          break;
        end
      end else begin
        exp_q.push_back(t[i]);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, 32'(sccb_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_error"}, 32'(error),      32'd0);
    chk({tag, "_index"}, 32'(index),      32'd0);
    chk({tag, "_reg"},   32'(sccb_reg),   32'd0);
    chk({tag, "_data"},  32'(sccb_data),  32'd0);
    chk({tag, "_id"},    32'(sccb_id),    32'h42);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_start(input bit m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done || error) break;
    end
    chk({tag, "_timeout"}, 32'(k < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_writes(input string tag, input int n);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (wlog.size() >= n) break;
    end
    chk({tag, "_wtimeout"}, 32'(k < 2000), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sccb_valid) break;
    end
    chk({tag, "_vtimeout"}, 32'(k < 200), 32'd1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 32'(wlog.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      chk(tag, 32'(wlog[i]), 32'(exp_q[i]));
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_done"},  32'(done),  32'(!exp_err));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_busy"},  32'(busy),  32'd0);
  endtask

  initial begin
    int gap;
    bit m;
    int nk;

    // asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1 chk_rst("por");
    do_reset();

    // stray done in IDLE
    inj_req++;
    repeat (3) @(negedge clk);
    chk_rst("stray");

    // mode 0 pass with start timing and start-while-busy
    model(1'b0, 0);
    @(negedge clk);
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("st_busy",  32'(busy),       32'd1);
    chk("st_valid", 32'(sccb_valid), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("st_valid1", 32'(sccb_valid), 32'd1);
    chk("st_reg",    32'(sccb_reg),   32'h12);
    chk("st_data",   32'(sccb_data),  32'h80);
    wait_writes("m0", 3);
    pulse_start(1'b1);
    wait_end("m0", 3000);
    check_log("m0");
    check_end("m0");
    gap = (wcyc.size() >= 2) ? wcyc[1] - wcyc[0] : -1;
    chk("m0_delay_min", 32'(gap >= 10 * CPM), 32'd1);
    chk("m0_delay",     32'(gap),             32'(10 * CPM + 6));

    // mode 1, mode toggled mid pass
    model(1'b1, 0);
    do_reset();
    pulse_start(1'b1);
    repeat (30) @(negedge clk);
    mode = 1'b0;
    repeat (200) @(negedge clk);
    mode = 1'b1;
    repeat (10) @(negedge clk);
    mode = 1'b0;
    wait_end("m1", 3000);
    check_log("m1");
    check_end("m1");

    // backpressure on entry 3
    stall_en = 1'b1;
    model(1'b0, 0);
    do_reset();
    pulse_start(1'b0);
    wait_end("bp", 3000);
    chk("bp_stable", 32'(stall_ok), 32'd20);
    check_log("bp");
    check_end("bp");
    stall_en = 1'b0;

    // two NACKs on entry 5
    nack_plan = 2;
    model(1'b0, 2);
    do_reset();
    pulse_start(1'b0);
    wait_end("nk2", 3000);
    check_log("nk2");
    check_end("nk2");

    // retries exhausted on entry 5
    nack_plan = 4;
    model(1'b0, 4);
    do_reset();
    pulse_start(1'b0);
    wait_end("nk4", 3000);
    repeat (50) @(negedge clk);
    check_log("nk4");
    check_end("nk4");
    chk("nk4_index", 32'(index),      32'(exp_idx));
    chk("nk4_valid", 32'(sccb_valid), 32'd0);
    nack_plan = 0;

    // reset during DELAY
    do_reset();
    pulse_start(1'b0);
    wait_writes("rd", 1);
    repeat (20) @(negedge clk);
    chk("rd_inbusy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_rst("rd");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // restart from entry 0, then reset during ISSUE
    pulse_start(1'b0);
    wait_valid("ri");
    chk("ri_reg",   32'(sccb_reg),  32'h12);
    chk("ri_data",  32'(sccb_data), 32'h80);
    chk("ri_index", 32'(index),     32'd0);
    #1 rst = 1'b1;
    #1 chk_rst("ri");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk_rst("ri_idle");
    model(1'b1, 0);
    pulse_start(1'b1);
    wait_end("ri", 3000);
    check_log("ri");
    check_end("ri");

    // randomized passes
    rnd_rdy = 1'b1;
    lat_lo  = 1;
    lat_hi  = 5;
    for (int r = 0; r < 4; r++) begin
      m         = 1'($urandom_range(0, 1));
      nk        = $urandom_range(0, 4);
      nack_plan = nk;
      model(m, nk);
      do_reset();
      pulse_start(m);
      wait_end("rnd", 4000);
      check_log("rnd");
      check_end("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
